// File: rtl/vga_timing_gen_if.sv
// Frame-buffer read port plus VGA pin bundle of the raster timing generator.
// The generator side (master) drives addresses and pins; memory/DAC side is the slave.
interface vga_timing_gen_if #(
  parameter int CW      = 11,
  parameter int COLOR_W = 1
);
  logic [3*COLOR_W-1:0] rgb;
  logic [CW-1:0]        oCtrH;
  logic [CW-1:0]        oCtrV;
  logic                 addr_valid;
  logic [COLOR_W-1:0]   RED;
  logic [COLOR_W-1:0]   GREEN;
  logic [COLOR_W-1:0]   BLUE;
  logic                 HS;
  logic                 VS;
  logic                 DE;
  logic                 line_start;
  logic                 frame_start;

  modport master (
    input  rgb,
    output oCtrH, oCtrV, addr_valid,
    output RED, GREEN, BLUE, HS, VS, DE, line_start, frame_start
  );

  modport slave (
    output rgb,
    input  oCtrH, oCtrV, addr_valid,
    input  RED, GREEN, BLUE, HS, VS, DE, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-buffer address output and
// a sync/colour alignment pipeline matched to the memory read latency.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 1,
  parameter int RD_LATENCY = 1,
  parameter int CW         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int RGB_W    = 3 * COLOR_W;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } sync_t;

  logic [CW-1:0] h_cnt_reg;
  logic [CW-1:0] v_cnt_reg;
  logic [CW-1:0] h_cnt_next;
  logic [CW-1:0] v_cnt_next;
  logic          h_last;
  logic          v_last;

  always_comb begin
    h_last     = (h_cnt_reg == CW'(H_TOTAL - 1));
    v_last     = (v_cnt_reg == CW'(V_TOTAL - 1));
    h_cnt_next = h_last ? '0 : h_cnt_reg + CW'(1);
    v_cnt_next = v_cnt_reg;
    if (h_last) begin
      v_cnt_next = v_last ? '0 : v_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (en) begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Stage-0 raster flags decoded straight from the counters.
  sync_t raw0;
  logic  hact;
  logic  vact;

  always_comb begin
    hact             = (h_cnt_reg < CW'(H_ACTIVE));
    vact             = (v_cnt_reg < CW'(V_ACTIVE));
    raw0             = '0;
    raw0.de          = hact & vact;
    raw0.hsync       = (h_cnt_reg >= CW'(HS_START)) && (h_cnt_reg < CW'(HS_END));
    raw0.vsync       = (v_cnt_reg >= CW'(VS_START)) && (v_cnt_reg < CW'(VS_END));
    raw0.line_start  = hact & vact & (h_cnt_reg == '0);
    raw0.frame_start = hact & vact & (h_cnt_reg == '0) & (v_cnt_reg == '0);
  end

  logic [CW-1:0] oCtrH_reg;
  logic [CW-1:0] oCtrV_reg;
  logic          addr_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      oCtrH_reg      <= '0;
      oCtrV_reg      <= '0;
      addr_valid_reg <= 1'b0;
    end else if (en) begin
      oCtrH_reg      <= raw0.de ? h_cnt_reg : '0;
      oCtrV_reg      <= raw0.de ? v_cnt_reg : '0;
      addr_valid_reg <= raw0.de;
    end
  end

  // pipe_reg[0] sits beside the address register; pipe_reg[RD_LATENCY] drives the pins.
  sync_t pipe_reg [0:RD_LATENCY];
  sync_t stage_in [0:RD_LATENCY];

  assign stage_in[0] = raw0;

  genvar gi;
  generate
    for (gi = 1; gi <= RD_LATENCY; gi++) begin : g_chain
      assign stage_in[gi] = pipe_reg[gi-1];
    end
  endgenerate

  logic [RGB_W-1:0] color_reg;

  // rgb is sampled on the same en edge that loads the final stage, so the
  // colour gate uses the DE bit about to enter that stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
      color_reg <= '0;
    end else if (en) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_reg[i] <= stage_in[i];
      end
      color_reg <= stage_in[RD_LATENCY].de ? bus.rgb : '0;
    end
  end

  sync_t out_stage;
  assign out_stage = pipe_reg[RD_LATENCY];

  assign bus.oCtrH       = oCtrH_reg;
  assign bus.oCtrV       = oCtrV_reg;
  assign bus.addr_valid  = addr_valid_reg;
  assign bus.DE          = out_stage.de;
  assign bus.HS          = HS_POL ? out_stage.hsync : ~out_stage.hsync;
  assign bus.VS          = VS_POL ? out_stage.vsync : ~out_stage.vsync;
  assign bus.line_start  = out_stage.line_start & en;
  assign bus.frame_start = out_stage.frame_start & en;
  assign bus.RED         = color_reg[RGB_W-1 -: COLOR_W];
  assign bus.GREEN       = color_reg[2*COLOR_W-1 -: COLOR_W];
  assign bus.BLUE        = color_reg[COLOR_W-1:0];

endmodule
